// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the SS.cc stopwatch controller.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam int          BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int          NUM_DIGITS = 4;
  localparam int          DISP_W     = 16;
endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// Mod-10 BCD digit; carry is combinational so a chain ripples within one cycle.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);
  assign carry = inc && (digit == BCD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n)   digit <= '0;
    else if (clr) digit <= '0;
    else if (inc) digit <= carry ? '0 : digit + 1'b1;
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller producing packed BCD SS.cc for the display.
// Optional lap freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int TICK_DIV = CLK_HZ / TICK_HZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic              btn_lap,
`endif
  output logic [DISP_W-1:0] disp_num,
  output logic              running,
  output logic              wrap_pulse
);
  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $error("stopwatch_ctrl: TICK_DIV must be >= 2");
    end
  endgenerate

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_clear, btn_start};
`endif

  // two-flop synchronizer plus history flop per button
  logic [NB-1:0] sync1, sync2, hist, ev;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end
  assign ev = sync2 & ~hist;

  logic start_ev, clear_ev;
  assign start_ev = ev[0];
  assign clear_ev = ev[1];

  state_t state_q, state_d;
  logic   clr_cnt;

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    case (state_q)
      IDLE:  if (clear_ev) clr_cnt = 1'b1;
             else if (start_ev) state_d = RUN;
      RUN:   if (start_ev) state_d = PAUSE;
      PAUSE: if (clear_ev) begin
               state_d = IDLE;
               clr_cnt = 1'b1;
             end else if (start_ev) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
    end
  end

  logic [PW-1:0] presc_q;
  logic          tick;
  assign tick = (presc_q == TERM) && (state_q == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n)                presc_q <= '0;
    else if (clr_cnt)          presc_q <= '0;
    else if (state_q == RUN)   presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  logic [NUM_DIGITS-1:0][BCD_W-1:0] digits;
  logic [NUM_DIGITS-1:0]            inc, carry;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      if (i == 0) begin : g_lsd
        assign inc[i] = tick;
      end else begin : g_up
        assign inc[i] = carry[i-1];
      end
      bcd_digit u_dig (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc[i]),
        .digit (digits[i]),
        .carry (carry[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) wrap_pulse <= 1'b0;
    else        wrap_pulse <= carry[NUM_DIGITS-1];
  end

`ifdef STOPWATCH_LAP_EN
  logic [DISP_W-1:0] lap_q;
  logic              frozen;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q  <= '0;
      frozen <= 1'b0;
    end else if (clr_cnt) begin
      frozen <= 1'b0;
    end else if (ev[2] && state_q == RUN) begin
      if (!frozen) lap_q <= digits;
      frozen <= ~frozen;
    end
  end
  assign disp_num = frozen ? lap_q : digits;
`else
  assign disp_num = digits;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: main instance at TICK_DIV=10, wrap instance at TICK_DIV=2.
module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start, btn_clear;
  logic        btn_start_w, btn_clear_w;
`ifdef STOPWATCH_LAP_EN
  logic        btn_lap, btn_lap_w;
`endif
  logic [15:0] disp_num, disp_w;
  logic        running, running_w, wrap_pulse, wrap_w;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap(btn_lap),
`endif
    .disp_num(disp_num), .running(running), .wrap_pulse(wrap_pulse)
  );

  stopwatch_ctrl #(.CLK_HZ(200), .TICK_HZ(100)) dut_w (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start_w), .btn_clear(btn_clear_w),
`ifdef STOPWATCH_LAP_EN
    .btn_lap(btn_lap_w),
`endif
    .disp_num(disp_w), .running(running_w), .wrap_pulse(wrap_w)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // button high for exactly three rising edges; returns right after the reacting edge
  task automatic press(input logic s, input logic c);
    btn_start = s; btn_clear = c;
    step(3);
    btn_start = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic press_w();
    btn_start_w = 1'b1;
    step(3);
    btn_start_w = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_start = 1'b1;
    step(3);
    total++; if (disp_num !== 16'h0000) $display("FAIL reset_disp got=%h exp=0000", disp_num); else passed++;
    total++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else passed++;
    total++; if (wrap_pulse !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap_pulse); else passed++;
    btn_start = 1'b0;
    rst_n = 1'b1;
    step(5);
    total++; if (running !== 1'b0) $display("FAIL reset_press_ignored running=%b exp=0", running); else passed++;
  endtask

  task automatic test_count();
    press(1'b1, 1'b0);
    total++; if (running !== 1'b1) $display("FAIL start_running got=%b exp=1", running); else passed++;
    step(9);
    total++; if (disp_num !== 16'h0000) $display("FAIL pre_first_tick got=%h exp=0000", disp_num); else passed++;
    step(1);
    total++; if (disp_num !== 16'h0001) $display("FAIL first_tick got=%h exp=0001", disp_num); else passed++;
    step(90);
    total++; if (disp_num !== 16'h0010) $display("FAIL ten_ticks got=%h exp=0010", disp_num); else passed++;
    step(900);
    total++; if (disp_num !== 16'h0100) $display("FAIL hundred_ticks got=%h exp=0100", disp_num); else passed++;
    total++; if (wrap_pulse !== 1'b0) $display("FAIL no_wrap got=%b exp=0", wrap_pulse); else passed++;
  endtask

  task automatic test_pause();
    press(1'b1, 1'b0);
    total++; if (running !== 1'b0 || disp_num !== 16'h0100)
      $display("FAIL pause1 running=%b disp=%h exp=0/0100", running, disp_num); else passed++;
    press(1'b0, 1'b1);
    total++; if (disp_num !== 16'h0000) $display("FAIL clear_pause got=%h exp=0000", disp_num); else passed++;
    press(1'b1, 1'b0);
    step(475);
    total++; if (disp_num !== 16'h0047) $display("FAIL at47 got=%h exp=0047", disp_num); else passed++;
    press(1'b1, 1'b0);
    step(200);
    total++; if (disp_num !== 16'h0047 || running !== 1'b0)
      $display("FAIL paused_hold disp=%h running=%b exp=0047/0", disp_num, running); else passed++;
    press(1'b1, 1'b0);
    total++; if (running !== 1'b1) $display("FAIL resume_running got=%b exp=1", running); else passed++;
    step(1);
    total++; if (disp_num !== 16'h0047) $display("FAIL resume_phase got=%h exp=0047", disp_num); else passed++;
    step(4);
    total++; if (disp_num !== 16'h0048) $display("FAIL resume_48 got=%h exp=0048", disp_num); else passed++;
  endtask

  task automatic test_clear_run();
    press(1'b0, 1'b1);
    total++; if (running !== 1'b1 || disp_num !== 16'h0048)
      $display("FAIL clear_in_run running=%b disp=%h exp=1/0048", running, disp_num); else passed++;
    step(744);
    total++; if (disp_num !== 16'h0123) $display("FAIL at123 got=%h exp=0123", disp_num); else passed++;
    press(1'b1, 1'b0);
    total++; if (running !== 1'b0 || disp_num !== 16'h0123)
      $display("FAIL pause123 running=%b disp=%h exp=0/0123", running, disp_num); else passed++;
    press(1'b1, 1'b1);
    total++; if (running !== 1'b0 || disp_num !== 16'h0000)
      $display("FAIL start_clear_pause running=%b disp=%h exp=0/0000", running, disp_num); else passed++;
    step(20);
    total++; if (disp_num !== 16'h0000) $display("FAIL idle_hold got=%h exp=0000", disp_num); else passed++;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic press_lap();
    btn_lap = 1'b1;
    step(3);
    btn_lap = 1'b0;
  endtask

  task automatic test_lap();
    press(1'b1, 1'b0);
    step(2500);
    total++; if (disp_num !== 16'h0250) $display("FAIL lap_live250 got=%h exp=0250", disp_num); else passed++;
    press_lap();
    step(300);
    total++; if (disp_num !== 16'h0250 || running !== 1'b1)
      $display("FAIL lap_frozen disp=%h running=%b exp=0250/1", disp_num, running); else passed++;
    press_lap();
    total++; if (disp_num !== 16'h0280) $display("FAIL lap_release got=%h exp=0280", disp_num); else passed++;
  endtask
`endif

  task automatic test_wrap();
    press_w();
    step(19998);
    total++; if (disp_w !== 16'h9999 || wrap_w !== 1'b0)
      $display("FAIL wrap_pre disp=%h wrap=%b exp=9999/0", disp_w, wrap_w); else passed++;
    step(1);
    total++; if (disp_w !== 16'h9999 || wrap_w !== 1'b0)
      $display("FAIL wrap_edge disp=%h wrap=%b exp=9999/0", disp_w, wrap_w); else passed++;
    step(1);
    total++; if (disp_w !== 16'h0000 || wrap_w !== 1'b1 || running_w !== 1'b1)
      $display("FAIL wrap disp=%h wrap=%b running=%b exp=0000/1/1", disp_w, wrap_w, running_w); else passed++;
    step(1);
    total++; if (wrap_w !== 1'b0) $display("FAIL wrap_width got=%b exp=0", wrap_w); else passed++;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step(1);
    total++; if (disp_num !== 16'h0000 || running !== 1'b0 || wrap_pulse !== 1'b0)
      $display("FAIL reset_mid disp=%h running=%b wrap=%b exp=0000/0/0", disp_num, running, wrap_pulse); else passed++;
    rst_n = 1'b1;
    step(3);
    total++; if (running !== 1'b0 || disp_w !== 16'h0000)
      $display("FAIL reset_mid_after running=%b disp_w=%h exp=0/0000", running, disp_w); else passed++;
  endtask

  initial begin
    btn_start = 1'b0; btn_clear = 1'b0;
    btn_start_w = 1'b0; btn_clear_w = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0; btn_lap_w = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_count();
    test_pause();
    test_clear_run();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences the 4-digit 7-segment display path as a stopwatch in SS.cc format (seconds, then hundredths).
- Generates the 16-bit packed BCD word consumed by display_switch as disp_num.
- The decimal point already sits after digit [11:8], so the display reads tens-sec, units-sec "." tenths, hundredths.
- Owns the run/pause/clear state machine, the 1/100 s prescaler and the cascaded BCD counters.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (one LSB = 10 ms).
- TICK_DIV, CLK_HZ/TICK_HZ, derived prescaler terminal count. Must be ≥2; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- btn_start  in  1  start/stop button level, asynchronous to clk, already debounced.
- btn_clear  in  1  clear button level, asynchronous to clk, already debounced.
- btn_lap  in  1  lap button level; exists only with STOPWATCH_LAP_EN.
- disp_num  out  16  packed BCD: [15:12] tens-sec, [11:8] units-sec, [7:4] tenths, [3:0] hundredths.
- running  out  1  high while in RUN.
- wrap_pulse  out  1  one-cycle pulse when the count rolls 99.99→00.00.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - state=IDLE, all four digits 0, prescaler 0.
  - disp_num=16'h0000, running=0, wrap_pulse=0, synchronizer flops 0.
- Button input path:
  - Each button goes through a 2-flop synchronizer plus one history flop.
  - Press event = sync2 & ~hist, one cycle wide.
  - State reacts on the 3rd rising edge after the button is first sampled high.
  - Holding a button produces exactly one event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start → RUN.
  - RUN + start → PAUSE.
  - PAUSE + start → RUN.
  - IDLE/PAUSE + clear → IDLE, digits and prescaler zeroed.
  - RUN + clear → ignored.
  - Start and clear events in the same cycle: in RUN, start wins (→PAUSE) and clear is dropped. In PAUSE or IDLE, clear wins and start is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Holds its value in PAUSE, so resuming preserves the sub-tick phase.
  - Zeroed on entry to IDLE.
  - tick = (prescaler==TICK_DIV-1) && RUN.
  - The first tick after IDLE→RUN occurs TICK_DIV cycles after running rises.
- BCD cascade:
  - Hundredths digit increments on tick.
  - Each digit wraps 9→0 and emits a carry to the next digit in the same cycle.
  - The tens-sec digit wraps 9→0 at 99.99, which asserts wrap_pulse for exactly that cycle; the FSM stays in RUN.
  - Digits are never outside 0..9, because the display decodes only 0-9.
- Output timing:
  - disp_num is registered and updates the cycle after the tick.
  - running is registered and follows the state with zero extra lag.
- Reset mid-count: state is lost immediately and there is no pulse on wrap_pulse.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- With the macro:
  - Adds btn_lap (same synchronizer and edge detection as the other buttons) and a 16-bit lap register.
  - Lap event in RUN: the lap register captures the live count, and disp_num shows the frozen lap value while counting continues internally.
  - A second lap event returns disp_num to the live count.
  - Clear also releases the lap freeze.
  - Lap events in IDLE/PAUSE are ignored.
  - Simultaneous lap and start in RUN: start is processed and the lap capture also takes the current value.
- Without the macro: no btn_lap port, and disp_num always shows the live count.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE}.
  - BCD_W=4, BCD_MAX=4'd9, NUM_DIGITS=4.
  - DISP_W=16.
- Sub-module bcd_digit:
  - Ports: clk, rst_n, clr, inc → digit[3:0], carry.
  - Mod-10 digit counter; four instances chained by carry.
- The synchronizer and edge detect stay inline; they are three flops per button.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so TICK_DIV=10):
- Hold rst_n=0 for 3 cycles → disp_num=0x0000, running=0, wrap_pulse=0. Button presses during reset are ignored.
- Start press, then run 10 ticks (100 cycles after running=1) → disp_num=0x0010. After 100 ticks → 0x0100.
- Run, press start after 47 ticks + 5 cycles, wait 200 cycles, press start again → disp_num holds 0x0047 while paused. After 5 more cycles in RUN → 0x0048.
- Preload to 0x9999 by letting 9999 ticks elapse, then one more tick → disp_num=0x0000, wrap_pulse high exactly 1 cycle, running stays 1.
- In RUN press clear → ignored. Press start and clear in the same cycle while paused at 0x0123 → IDLE, 0x0000, running=0.
- With STOPWATCH_LAP_EN: lap at 0x0250 → disp_num frozen at 0x0250 for 300 cycles. Second lap → disp_num=0x0280.
